// File: rtl/thor2022_icache_refill_ctrl_if.sv
// Fetch, refill-bus and array-update signals of the icache refill controller.
// master = controller side, slave = cache arrays / bus fabric side.
interface thor2022_icache_refill_ctrl_if #(
   parameter int unsigned AWID = 32,
   parameter int unsigned BUSW = 128,
   parameter int unsigned IDXW = 7
);
   logic            req;
   logic [AWID-1:0] ip;
   logic            ihit;
   logic [1:0]      hit_way;
   logic            invall;
   logic            invline;
   logic [AWID-1:0] inv_adr;
   logic            ready;
   logic            fault;
   logic            busy;
   logic            bus_cyc;
   logic            bus_stb;
   logic [AWID-1:0] bus_adr;
   logic            bus_ack;
   logic            bus_err;
   logic [BUSW-1:0] bus_dat;
   logic            wr;
   logic [1:0]      wr_way;
   logic [IDXW-1:0] wr_idx;
   logic [AWID-7:0] wr_tag;
   logic [511:0]    wr_line;
   logic            vclr;
   logic            vclr_all;
   logic [IDXW-1:0] vclr_idx;

   modport master (
      input  req, ip, ihit, hit_way, invall, invline, inv_adr, bus_ack, bus_err, bus_dat,
      output ready, fault, busy, bus_cyc, bus_stb, bus_adr, wr, wr_way, wr_idx, wr_tag,
             wr_line, vclr, vclr_all, vclr_idx
   );

   modport slave (
      output req, ip, ihit, hit_way, invall, invline, inv_adr, bus_ack, bus_err, bus_dat,
      input  ready, fault, busy, bus_cyc, bus_stb, bus_adr, wr, wr_way, wr_idx, wr_tag,
             wr_line, vclr, vclr_all, vclr_idx
   );
endinterface

// File: rtl/thor2022_icache_refill_ctrl.sv
// Icache refill sequencer: hit check, line refill over the bus, invalidates.
// THOR2022_ICACHE_LFSR_REPL_EN selects LFSR victim choice instead of round-robin.
module thor2022_icache_refill_ctrl #(
   parameter int unsigned AWID = 32,
   parameter int unsigned BUSW = 128,
   parameter int unsigned IDXW = 7
) (
   input logic                           clk,
   input logic                           rst,
   thor2022_icache_refill_ctrl_if.master io_ic
);
   localparam int unsigned NBEAT = 512 / BUSW;
   localparam int unsigned BEATW = $clog2(NBEAT);
   localparam int unsigned OFFW  = $clog2(BUSW / 8);
   localparam int unsigned TAGW  = AWID - 6;

   typedef enum logic [1:0] {StIdle, StLookup, StFetch, StWrite} state_e;

   state_e           r_state, w_state_nxt;
   logic [BEATW-1:0] r_beat;
   logic [BEATW-1:0] w_beat_inc;
   logic [TAGW-1:0]  r_miss_tag;
   logic [1:0]       r_victim;
   logic [1:0]       w_victim_src;
   logic [511:0]     r_line;
   logic [AWID-1:0]  r_bus_adr;
   logic             r_inv_all;
   logic             r_inv_line;
   logic [IDXW-1:0]  r_inv_idx;
   logic             r_fault;
   logic             w_last;
   logic             w_clr_all;
   logic             w_clr_line;
   logic             w_miss;
   logic             w_ready, w_busy, w_cyc, w_wr, w_vclr, w_vclr_all;
   logic             w_unused;

   assign w_beat_inc = r_beat + BEATW'(1);
   assign w_last     = (r_beat == BEATW'(NBEAT - 1));
   assign w_clr_all  = (r_state == StIdle) & r_inv_all;
   assign w_clr_line = (r_state == StIdle) & ~r_inv_all & r_inv_line;
   assign w_miss     = (r_state == StLookup) & (w_state_nxt == StFetch);
   assign w_unused   = ^{io_ic.hit_way, io_ic.ip[5:0], io_ic.inv_adr[AWID-1:IDXW+6],
                         io_ic.inv_adr[5:0]};

   always_ff @(posedge clk) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:   if (!r_inv_all && !r_inv_line && io_ic.req) w_state_nxt = StLookup;
         StLookup: w_state_nxt = (!io_ic.req || io_ic.ihit) ? StIdle : StFetch;
         StFetch: begin
            if (io_ic.bus_err)                 w_state_nxt = StIdle;
            else if (io_ic.bus_ack && w_last)  w_state_nxt = StWrite;
         end
         StWrite:  w_state_nxt = StLookup;
         default:  w_state_nxt = StIdle;
      endcase
   end

   always_comb begin
      w_ready    = 1'b0;
      w_cyc      = 1'b0;
      w_wr       = 1'b0;
      w_vclr     = 1'b0;
      w_vclr_all = 1'b0;
      w_busy     = (r_state != StIdle);
      unique case (r_state)
         StIdle: begin
            w_vclr_all = r_inv_all;
            w_vclr     = ~r_inv_all & r_inv_line;
         end
         StLookup: w_ready = io_ic.req & io_ic.ihit;
         StFetch:  w_cyc   = 1'b1;
         StWrite:  w_wr    = 1'b1;
         default:  w_busy  = 1'b1;
      endcase
   end

   // Invalidate requests are latched in every state; a new request wins over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inv_all  <= 1'b0;
         r_inv_line <= 1'b0;
         r_inv_idx  <= '0;
         r_fault    <= 1'b0;
         r_beat     <= '0;
         r_miss_tag <= '0;
         r_victim   <= '0;
         r_line     <= '0;
         r_bus_adr  <= '0;
      end else begin
         r_inv_all  <= (r_inv_all & ~w_clr_all) | io_ic.invall;
         r_inv_line <= (r_inv_line & ~w_clr_line) | io_ic.invline;
         if (io_ic.invline) r_inv_idx <= io_ic.inv_adr[IDXW+5:6];
         r_fault <= (r_state == StFetch) & io_ic.bus_err;
         if (w_miss) begin
            r_miss_tag <= io_ic.ip[AWID-1:6];
            r_victim   <= w_victim_src;
            r_beat     <= '0;
            r_bus_adr  <= {io_ic.ip[AWID-1:6], {(BEATW + OFFW){1'b0}}};
         end
         if ((r_state == StFetch) && !io_ic.bus_err && io_ic.bus_ack) begin
            for (int i = 0; i < NBEAT; i++) begin
               if (r_beat == BEATW'(i)) r_line[i*BUSW +: BUSW] <= io_ic.bus_dat;
            end
            r_beat <= w_beat_inc;
            if (!w_last) r_bus_adr <= {r_miss_tag, w_beat_inc, {OFFW{1'b0}}};
         end
      end
   end

`ifdef THOR2022_ICACHE_LFSR_REPL_EN
   logic [15:0] r_lfsr;
   logic        w_fb;

   assign w_fb         = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_victim_src = r_lfsr[1:0];

   always_ff @(posedge clk) begin
      if (rst) r_lfsr <= 16'hACE1;
      else     r_lfsr <= {r_lfsr[14:0], w_fb};
   end
`else
   logic [1:0] r_rr;

   assign w_victim_src = r_rr;

   always_ff @(posedge clk) begin
      if (rst)                       r_rr <= 2'd0;
      else if (r_state == StWrite)   r_rr <= r_rr + 2'd1;
   end
`endif

   assign io_ic.ready    = w_ready;
   assign io_ic.fault    = r_fault;
   assign io_ic.busy     = w_busy;
   assign io_ic.bus_cyc  = w_cyc;
   assign io_ic.bus_stb  = w_cyc;
   assign io_ic.bus_adr  = r_bus_adr;
   assign io_ic.wr       = w_wr;
   assign io_ic.wr_way   = r_victim;
   assign io_ic.wr_idx   = r_miss_tag[IDXW-1:0];
   assign io_ic.wr_tag   = r_miss_tag;
   assign io_ic.wr_line  = r_line;
   assign io_ic.vclr     = w_vclr;
   assign io_ic.vclr_all = w_vclr_all;
   assign io_ic.vclr_idx = r_inv_idx;
endmodule

// File: tb/tb_thor2022_icache_refill_ctrl.sv
// Directed bench for thor2022_icache_refill_ctrl: vector table plus corner sequences.
module tb_thor2022_icache_refill_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ack_en = 1'b1;
   logic err_en = 1'b0;
   logic [1:0] err_beat = 2'd0;
   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   thor2022_icache_refill_ctrl_if u_if ();

   thor2022_icache_refill_ctrl u_dut (
      .clk   (clk),
      .rst   (rst),
      .io_ic (u_if.master)
   );

   // Zero-wait responder: beat data equals the beat number.
   assign u_if.bus_ack = u_if.bus_cyc & ack_en;
   assign u_if.bus_err = u_if.bus_cyc & err_en & (u_if.bus_adr[5:4] == err_beat);
   assign u_if.bus_dat = {126'd0, u_if.bus_adr[5:4]};

`ifdef THOR2022_ICACHE_LFSR_REPL_EN
   logic [15:0] m_lfsr;
   logic [1:0]  m_vict;
   always @(posedge clk) begin
      if (rst) m_lfsr <= 16'hACE1;
      else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (!rst && u_if.busy && !u_if.bus_cyc && !u_if.wr && u_if.req && !u_if.ihit)
         m_vict <= m_lfsr[1:0];
   end
`endif

   typedef struct {
      logic        rst, req, ihit;
      logic [31:0] ip;
      logic        e_ready, e_busy, e_cyc, e_wr;
      logic [31:0] e_adr;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic q, input logic h, input logic [31:0] a,
                               input logic er, input logic eb, input logic ec, input logic ew,
                               input logic [31:0] ea);
      vec_t v;
      v.rst = r; v.req = q; v.ihit = h; v.ip = a;
      v.e_ready = er; v.e_busy = eb; v.e_cyc = ec; v.e_wr = ew; v.e_adr = ea;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // Full miss/refill/re-check; exp_way is the round-robin expectation.
   task automatic run_fetch(input logic [31:0] a, input logic [1:0] exp_way, input string nm);
      logic seen_wr, seen_rdy, seen_adr;
      logic [1:0] ew;
      seen_wr = 1'b0; seen_rdy = 1'b0; seen_adr = 1'b0;
      u_if.ip = a; u_if.req = 1'b1; u_if.ihit = 1'b0;
      for (int n = 0; n < 30 && !seen_rdy; n++) begin
         step();
         if (seen_wr) u_if.ihit = 1'b1;
         #1;
         if (u_if.bus_cyc && !seen_adr) begin
            seen_adr = 1'b1;
            chk({nm, " first adr"}, u_if.bus_adr, {a[31:6], 6'b0});
         end
         if (u_if.wr) begin
            seen_wr = 1'b1;
`ifdef THOR2022_ICACHE_LFSR_REPL_EN
            ew = m_vict;
`else
            ew = exp_way;
`endif
            chk({nm, " wr_way"}, u_if.wr_way, ew);
            chk({nm, " wr_idx"}, u_if.wr_idx, a[12:6]);
         end
         if (u_if.ready) seen_rdy = 1'b1;
      end
      chk({nm, " ready"}, seen_rdy, 1'b1);
      u_if.req = 1'b0;
      u_if.ihit = 1'b0;
   endtask

   vec_t tv[13];
   logic [511:0] exp_line;
   logic found;

   initial begin
      u_if.req = 1'b0; u_if.ip = '0; u_if.ihit = 1'b0; u_if.hit_way = 2'd2;
      u_if.invall = 1'b0; u_if.invline = 1'b0; u_if.inv_adr = '0;
      exp_line = {128'd3, 128'd2, 128'd1, 128'd0};

      //            rst req hit ip            rdy busy cyc wr adr
      tv[0]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0);
      tv[1]  = mk(0, 1, 0, 32'h100,      0, 0, 0, 0, 32'h0);
      tv[2]  = mk(0, 1, 1, 32'h100,      1, 1, 0, 0, 32'h0);
      tv[3]  = mk(0, 0, 0, 32'h100,      0, 0, 0, 0, 32'h0);
      tv[4]  = mk(0, 1, 0, 32'h1240,     0, 0, 0, 0, 32'h0);
      tv[5]  = mk(0, 1, 0, 32'h1240,     0, 1, 0, 0, 32'h0);
      tv[6]  = mk(0, 1, 0, 32'h1240,     0, 1, 1, 0, 32'h1240);
      tv[7]  = mk(0, 1, 0, 32'h1240,     0, 1, 1, 0, 32'h1250);
      tv[8]  = mk(0, 1, 0, 32'h1240,     0, 1, 1, 0, 32'h1260);
      tv[9]  = mk(0, 1, 0, 32'h1240,     0, 1, 1, 0, 32'h1270);
      tv[10] = mk(0, 1, 0, 32'h1240,     0, 1, 0, 1, 32'h1270);
      tv[11] = mk(0, 1, 1, 32'h1240,     1, 1, 0, 0, 32'h1270);
      tv[12] = mk(0, 0, 0, 32'h1240,     0, 0, 0, 0, 32'h1270);

      do_reset();
      for (int i = 0; i < 13; i++) begin
         if (i > 0) step();
         rst = tv[i].rst; u_if.req = tv[i].req; u_if.ihit = tv[i].ihit; u_if.ip = tv[i].ip;
         #1;
         chk($sformatf("v%0d ready", i), u_if.ready, tv[i].e_ready);
         chk($sformatf("v%0d busy", i), u_if.busy, tv[i].e_busy);
         chk($sformatf("v%0d cyc", i), u_if.bus_cyc, tv[i].e_cyc);
         chk($sformatf("v%0d stb", i), u_if.bus_stb, tv[i].e_cyc);
         chk($sformatf("v%0d wr", i), u_if.wr, tv[i].e_wr);
         chk($sformatf("v%0d adr", i), u_if.bus_adr, tv[i].e_adr);
         chk($sformatf("v%0d fault", i), u_if.fault, 1'b0);
         if (tv[i].e_wr) begin
            // ip[12:6] of 0x1240 is 0x49
            chk("miss wr_idx", u_if.wr_idx, 7'h49);
            chk("miss wr_tag", u_if.wr_tag, 26'h49);
            chk("miss wr_line", u_if.wr_line, exp_line);
`ifndef THOR2022_ICACHE_LFSR_REPL_EN
            chk("miss wr_way", u_if.wr_way, 2'd0);
`endif
         end
      end

      // Round-robin over five misses
      do_reset();
      run_fetch(32'h5000, 2'd0, "rr0");
      run_fetch(32'h5040, 2'd1, "rr1");
      run_fetch(32'h5080, 2'd2, "rr2");
      run_fetch(32'h50C0, 2'd3, "rr3");
      run_fetch(32'h5100, 2'd0, "rr4");

      // Bus error on beat 2
      err_en = 1'b1; err_beat = 2'd2;
      u_if.ip = 32'h6000; u_if.req = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         step();
         #1;
         if (u_if.bus_cyc && u_if.bus_adr[5:4] == 2'd2) found = 1'b1;
      end
      chk("err reached", found, 1'b1);
      chk("err pre fault", u_if.fault, 1'b0);
      step();
      u_if.req = 1'b0;
      #1;
      chk("err fault", u_if.fault, 1'b1);
      chk("err cyc", u_if.bus_cyc, 1'b0);
      chk("err stb", u_if.bus_stb, 1'b0);
      chk("err busy", u_if.busy, 1'b0);
      chk("err wr", u_if.wr, 1'b0);
      step();
      #1;
      chk("err fault pulse", u_if.fault, 1'b0);
      chk("err idle", u_if.busy, 1'b0);
      err_en = 1'b0;
      run_fetch(32'h6000, 2'd1, "after err");

      // invall during refill, invline in IDLE
      u_if.ip = 32'h3000; u_if.req = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         step();
         #1;
         if (u_if.bus_cyc) found = 1'b1;
      end
      chk("inv fetch", found, 1'b1);
      u_if.invall = 1'b1;
      step();
      u_if.invall = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         #1;
         if (u_if.wr) found = 1'b1;
         else step();
      end
      chk("inv wr", found, 1'b1);
      chk("inv no early clr", u_if.vclr_all, 1'b0);
      step();
      u_if.ihit = 1'b1;
      #1;
      chk("inv ready", u_if.ready, 1'b1);
      chk("inv ready no clr", u_if.vclr_all, 1'b0);
      step();
      u_if.ihit = 1'b0; u_if.invline = 1'b1; u_if.inv_adr = 32'h0000_0080;
      #1;
      chk("inv vclr_all", u_if.vclr_all, 1'b1);
      chk("inv vclr_all busy", u_if.busy, 1'b0);
      chk("inv vclr first", u_if.vclr, 1'b0);
      step();
      u_if.invline = 1'b0;
      #1;
      chk("inv vclr", u_if.vclr, 1'b1);
      chk("inv vclr_idx", u_if.vclr_idx, 7'h02);
      chk("inv vclr_all off", u_if.vclr_all, 1'b0);
      step();
      #1;
      chk("inv vclr off", u_if.vclr, 1'b0);
      chk("inv pre lookup", u_if.busy, 1'b0);
      step();
      u_if.ihit = 1'b1;
      #1;
      chk("inv req served", u_if.ready, 1'b1);
      step();
      u_if.req = 1'b0; u_if.ihit = 1'b0;

      // Reset mid-refill after two acks
      u_if.ip = 32'h4000; u_if.req = 1'b1;
      found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         step();
         #1;
         if (u_if.bus_cyc && u_if.bus_adr[5:4] == 2'd2) found = 1'b1;
      end
      chk("rst beat2", found, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0; u_if.req = 1'b0;
      #1;
      chk("rst cyc", u_if.bus_cyc, 1'b0);
      chk("rst stb", u_if.bus_stb, 1'b0);
      chk("rst busy", u_if.busy, 1'b0);
      chk("rst wr", u_if.wr, 1'b0);
      step();
      #1;
      chk("rst still no wr", u_if.wr, 1'b0);
      run_fetch(32'h4000, 2'd0, "after rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
